slow_tick_ctrl: RTL and testbench
=================================

// Module: slow_tick_ctrl
// PURPOSE
//  Run/step controller for the CLA slow-clock path on Nexys4 DDR.
//  - Produces a one-cycle clock-enable pulse, tick_en, every div_q cycles of the 100 MHz clock_in.
//  - Sequences it as free-run, single-step or idle, so CLA stages are observed at human speed.
//  - Divisor is loaded at runtime through a valid/ready handshake.
//  - Downstream logic stays on clock_in and qualifies with tick_en; no derived clocks.
// PARAMETERS
//  CNT_W       32           width of divisor and period counter
//  DEFAULT_DIV 100_000_000  div_q after reset (1 Hz tick at 100 MHz)
//  TCNT_W      16           width of tick_cnt
// PORTS
//  clock_in   in   1       system clock, 100 MHz
//  reset_n    in   1       asynchronous active-low reset
//  cfg_valid  in   1       divisor load request
//  cfg_div    in   CNT_W   new divisor; 0 is loaded as 1
//  cfg_ready  out  1       divisor can be accepted (high only in IDLE)
//  run        in   1       level: free-run while high
//  step       in   1       pulse: issue exactly one tick from IDLE
//  tick_en    out  1       one-cycle enable pulse
//  tick_cnt   out  TCNT_W  ticks issued since reset, wraps to 0
//  state      out  2       current FSM state
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation):
//   - state=IDLE, cnt=0, div_q=DEFAULT_DIV, tick_en=0, tick_cnt=0, busy=0, cfg_ready=1.
//  FSM states: IDLE=0, RUN=1, STEP=2; encoding 3 is unreachable and decodes to IDLE.
//  IDLE:
//   - cnt held at 0.
//   - run=1 -> RUN.
//   - else step=1 -> STEP.
//  RUN:
//   - cnt increments each cycle.
//   - At cnt==div_q-1: cnt<=0 and tick_en registered high for the next cycle.
//   - run=0 -> IDLE on the next edge; cnt cleared.
//   - A tick already registered still appears; no further ticks.
//  STEP:
//   - Counts identically.
//   - On terminal count: one tick is issued, then -> IDLE.
//   - run and step are ignored until the state returns to IDLE.
//  Timing and counters:
//   - First tick appears div_q cycles after the edge that enters RUN/STEP.
//   - Tick period is exactly div_q cycles.
//   - div_q=1: tick_en high on every cycle in RUN.
//   - tick_cnt increments in the cycle tick_en is high; wraps at 2^TCNT_W-1 -> 0.
//  Config handshake:
//   - cfg_ready = (state==IDLE).
//   - Accept on cfg_valid&cfg_ready at the edge; div_q <= max(cfg_div,1).
//   - Accept and run=1 on the same edge: the new div_q governs the first period.
//   - cfg_valid while busy: held off, no effect.
//  Simultaneous run and step in IDLE: run wins, step is dropped.
// CONFIGURATION
//  LED_CLK_OUT_EN:
//   - Defined: adds output port clock_out (1 bit, reset 0).
//   - clock_out toggles on each cycle tick_en is high: a 50% square wave, period 2*div_q, for an LED.
//   - Undefined: port and register absent; all other behaviour is identical.
// STRUCTURE
//  Package cla_clk_pkg:
//   - ST_IDLE/ST_RUN/ST_STEP 2-bit localparams.
//   - DEFAULT_DIV, CLK_HZ=100_000_000.
//  Sub-module tick_counter (CNT_W):
//   - Inputs: clear, enable, div_q.
//   - Outputs: terminal flag, cnt.
//  The FSM, handshake and tick_cnt stay in slow_tick_ctrl.
// TESTING
//  1. Reset, no stimulus -> tick_en=0, tick_cnt=0, cfg_ready=1, state=0 for 50 cycles.
//  2. cfg_div=4 accepted, run=1 for 20 cycles -> tick_en high at cycles 4,8,12,16,20 after entry;
//     tick_cnt=5; cfg_ready=0 throughout.
//  3. cfg_div=3, step pulse -> single tick 3 cycles later, state back to 0;
//     a second step while in STEP -> no extra tick.
//  4. cfg_div=0 accepted, run=1 -> tick_en high every cycle;
//     cfg_valid with cfg_div=7 during RUN -> ignored, period unchanged after re-run.
//  5. run=1, div=5; reset_n low at cnt=2 -> outputs zero immediately;
//     after release, IDLE with div_q=DEFAULT_DIV.
//  6. TCNT_W=4, div=1, run 17 cycles -> tick_cnt wraps 15->0 and reads 1;
//     with LED_CLK_OUT_EN, clock_out toggles on every tick.

Source files
------------

// File: rtl/cla_clk_pkg.sv
// cla_clk_pkg: shared state encodings and clock constants for the CLA slow-tick path.
// Rev 1.0
`default_nettype none

package cla_clk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned DEFAULT_DIV = CLK_HZ;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_STEP = ST_STEP
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tick_counter.sv
// tick_counter: period counter that wraps at div_q-1 and flags the terminal count.
// Rev 1.0
`default_nettype none

module tick_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_q,
  output logic             terminal,
  output logic [CNT_W-1:0] cnt
);

  // div_q is never zero, so div_q-1 cannot underflow.
  assign terminal = (cnt == (div_q - CNT_W'(1)));

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= terminal ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/slow_tick_ctrl.sv
// slow_tick_ctrl: free-run/single-step tick_en controller with runtime divisor load.
// Rev 1.0 -- define LED_CLK_OUT_EN to add the clock_out LED square wave.
`default_nettype none

module slow_tick_ctrl
  import cla_clk_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = cla_clk_pkg::DEFAULT_DIV,
  parameter int unsigned TCNT_W      = 16
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  input  logic              run,
  input  logic              step,
  output logic              tick_en,
  output logic [TCNT_W-1:0] tick_cnt,
  output logic [1:0]        state,
  output logic              busy
`ifdef LED_CLK_OUT_EN
  ,
  output logic              clock_out
`endif
);

  state_t           state_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt;
  logic             terminal;
  logic             cnt_en;
  logic             tick_due;

  // Counting stops on the same edge that run drops, so no tick can follow.
  always_comb begin
    cnt_en   = ((state_q == S_RUN) && run) || (state_q == S_STEP);
    tick_due = cnt_en && terminal;
  end

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .clear    (!cnt_en),
    .enable   (cnt_en),
    .div_q    (div_q),
    .terminal (terminal),
    .cnt      (cnt)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= CNT_W'(DEFAULT_DIV);
      tick_en  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      tick_en  <= tick_due;
      tick_cnt <= tick_cnt + TCNT_W'(tick_due);
      case (state_q)
        S_RUN: begin
          if (!run) state_q <= S_IDLE;
        end
        S_STEP: begin
          if (terminal) state_q <= S_IDLE;
        end
        default: begin
          if (cfg_valid) div_q <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
          if (run)       state_q <= S_RUN;
          else if (step) state_q <= S_STEP;
          else           state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LED_CLK_OUT_EN
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) clock_out <= 1'b0;
    else if (tick_due) clock_out <= ~clock_out;
  end
`endif

  always_comb begin
    state     = state_q;
    busy      = (state_q == S_RUN) || (state_q == S_STEP);
    cfg_ready = !busy;
  end

  // Divisor only changes while the counter is parked at zero, so cnt stays below it.
  assert property (@(posedge clock_in) disable iff (!reset_n) (cnt < div_q));

endmodule

`default_nettype wire

// File: tb/tb_slow_tick_ctrl.sv
// tb_slow_tick_ctrl: directed vector table plus reset, default-divisor and wrap sequences.
// Rev 1.0
`default_nettype none

module tb_slow_tick_ctrl;
  import cla_clk_pkg::*;

  localparam int unsigned TB_DEF_DIV = 12;

  logic        clock_in  = 1'b0;
  logic        reset_n   = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_div   = '0;
  logic        run       = 1'b0;
  logic        step      = 1'b0;
  logic        cfg_ready;
  logic        tick_en;
  logic [3:0]  tick_cnt;
  logic [1:0]  state;
  logic        busy;
`ifdef LED_CLK_OUT_EN
  logic        clock_out;
`endif

  slow_tick_ctrl #(
    .CNT_W       (32),
    .DEFAULT_DIV (TB_DEF_DIV),
    .TCNT_W      (4)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .run       (run),
    .step      (step),
    .tick_en   (tick_en),
    .tick_cnt  (tick_cnt),
    .state     (state),
    .busy      (busy)
`ifdef LED_CLK_OUT_EN
    ,
    .clock_out (clock_out)
`endif
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cv;
    int unsigned cd;
    int unsigned r;
    int unsigned s;
    int unsigned tick;
    int unsigned tcnt;
    int unsigned st;
    int unsigned rdy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input int unsigned cv, input int unsigned cd,
                              input int unsigned r, input int unsigned s,
                              input int unsigned tick, input int unsigned tcnt,
                              input int unsigned st, input int unsigned rdy);
    vec_t v;
    v.cv = cv; v.cd = cd; v.r = r; v.s = s;
    v.tick = tick; v.tcnt = tcnt; v.st = st; v.rdy = rdy;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check_outs(input string tag, input int unsigned tick, input int unsigned tcnt,
                            input int unsigned st, input int unsigned rdy);
    check({tag, " tick_en"},   32'(tick_en),   tick);
    check({tag, " tick_cnt"},  32'(tick_cnt),  tcnt);
    check({tag, " state"},     32'(state),     st);
    check({tag, " cfg_ready"}, 32'(cfg_ready), rdy);
    check({tag, " busy"},      32'(busy),      (st != 0) ? 32'd1 : 32'd0);
`ifdef LED_CLK_OUT_EN
    check({tag, " clock_out"}, 32'(clock_out), tcnt % 2);
`endif
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    int first_tick;

    // Idle after reset: nothing moves for 50 cycles.
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      check_outs($sformatf("idle%0d", i), 0, 0, ST_IDLE, 1);
    end

    // Free run at div 4 for 20 cycles, then stop.
    add(1, 4, 1, 0, 0, 0, ST_RUN, 0);
    for (int k = 1; k <= 20; k++)
      add(0, 0, 1, 0, (k % 4 == 0) ? 1 : 0, k / 4, ST_RUN, 0);
    add(0, 0, 0, 0, 0, 5, ST_IDLE, 1);
    // Single step at div 3, with a repeated step while stepping.
    add(1, 3, 0, 0, 0, 5, ST_IDLE, 1);
    add(0, 0, 0, 1, 0, 5, ST_STEP, 0);
    add(0, 0, 0, 1, 0, 5, ST_STEP, 0);
    add(0, 0, 0, 0, 0, 5, ST_STEP, 0);
    add(0, 0, 0, 0, 1, 6, ST_IDLE, 1);
    add(0, 0, 0, 0, 0, 6, ST_IDLE, 1);
    // run and step together: run wins.
    add(0, 0, 1, 1, 0, 6, ST_RUN, 0);
    add(0, 0, 0, 0, 0, 6, ST_IDLE, 1);
    // Divisor 0 loads as 1; a load attempt while running is ignored.
    add(1, 0, 1, 0, 0, 6, ST_RUN, 0);
    add(0, 0, 1, 0, 1, 7, ST_RUN, 0);
    add(0, 0, 1, 0, 1, 8, ST_RUN, 0);
    add(0, 0, 1, 0, 1, 9, ST_RUN, 0);
    add(1, 7, 1, 0, 1, 10, ST_RUN, 0);
    add(0, 0, 1, 0, 1, 11, ST_RUN, 0);
    add(0, 0, 0, 0, 0, 11, ST_IDLE, 1);
    add(0, 0, 1, 0, 0, 11, ST_RUN, 0);
    add(0, 0, 1, 0, 1, 12, ST_RUN, 0);
    add(0, 0, 1, 0, 1, 13, ST_RUN, 0);
    add(0, 0, 0, 0, 0, 13, ST_IDLE, 1);

    for (int i = 0; i < vq.size(); i++) begin
      cfg_valid = vq[i].cv[0];
      cfg_div   = vq[i].cd;
      run       = vq[i].r[0];
      step      = vq[i].s[0];
      cycle();
      check_outs($sformatf("vec%0d", i), vq[i].tick, vq[i].tcnt, vq[i].st, vq[i].rdy);
    end
    cfg_valid = 1'b0; run = 1'b0; step = 1'b0; cfg_div = '0;

    // Asynchronous reset mid-run at cnt=2, after one tick has been counted.
    reset_pulse();
    cfg_valid = 1'b1; cfg_div = 32'd5; run = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    repeat (7) cycle();
    check("prereset tick_cnt", 32'(tick_cnt), 1);
    check("prereset state", 32'(state), ST_RUN);
    #2 reset_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, ST_IDLE, 1);
    run = 1'b0;
    cycle();
    reset_n = 1'b1;
    run = 1'b1;
    cycle();
    first_tick = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (tick_en && first_tick == 0) first_tick = i;
    end
    check("default div period", 32'(first_tick), TB_DEF_DIV);
    run = 1'b0;
    cycle();

    // tick_cnt wrap at div 1.
    reset_pulse();
    cfg_valid = 1'b1; cfg_div = 32'd0; run = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      cycle();
      check_outs($sformatf("wrap%0d", k), 1, k % 16, ST_RUN, 0);
    end
    run = 1'b0;
    cycle();
    check_outs("wrap_stop", 0, 1, ST_IDLE, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
